// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential non-restoring divider.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CALC = 3'd1,
        FIX  = 3'd2,
        NEG  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int SEQ_DIV_WIDTH = 8;
    localparam int SEQ_DIV_CNT_W = $clog2(SEQ_DIV_WIDTH);

endpackage

// File: rtl/seq_divider_div_step.sv
// One add/subtract row of the non-restoring divider: optional left shift of P
// with a quotient bit shifted in, then P +/- D; reused every CALC cycle and in FIX.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic [WIDTH:0] i_p,
    input  logic [WIDTH:0] i_d,
    input  logic           i_shift_bit,
    input  logic           i_shift_en,
    input  logic           i_sub,
    output logic [WIDTH:0] o_p,
    output logic           o_q_bit
);

    logic [WIDTH:0] w_operand;

    always_comb begin
        w_operand = i_shift_en ? {i_p[WIDTH-1:0], i_shift_bit} : i_p;
        o_p       = i_sub ? (w_operand - i_d) : (w_operand + i_d);
        // A non-negative partial remainder means the trial subtraction fit.
        o_q_bit   = ~o_p[WIDTH];
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative non-restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a NEG state).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = SEQ_DIV_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_By_Zero,
    output logic [2:0]       o_dbg_state
);

    localparam int CNT_W = (WIDTH == SEQ_DIV_WIDTH) ? SEQ_DIV_CNT_W : $clog2(WIDTH);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds data stable while valid is high and not accepted.

    state_t             r_state;
    logic [WIDTH:0]     r_p;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_d;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_sub;
    logic [WIDTH:0]     w_p_next;
    logic               w_q_bit;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic               r_q_neg;
    logic               r_r_neg;

    assign w_dvd_mag = Dividend[WIDTH-1] ? (~Dividend + 1'b1) : Dividend;
    assign w_dvs_mag = Divisor[WIDTH-1]  ? (~Divisor + 1'b1)  : Divisor;
`else
    assign w_dvd_mag = Dividend;
    assign w_dvs_mag = Divisor;
`endif

    assign w_accept  = In_Valid & r_in_ready;
    // CALC picks the operation from the old sign; FIX only ever adds back.
    assign w_sub     = (r_state == CALC) && !r_p[WIDTH];
    assign w_rem_fix = r_p[WIDTH] ? w_p_next[WIDTH-1:0] : r_p[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_p        (r_p),
        .i_d        ({1'b0, r_d}),
        .i_shift_bit(r_q[WIDTH-1]),
        .i_shift_en (r_state == CALC),
        .i_sub      (w_sub),
        .o_p        (w_p_next),
        .o_q_bit    (w_q_bit)
    );

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state     <= IDLE;
            r_p         <= '0;
            r_q         <= '0;
            r_d         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (Divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= Dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_p     <= '0;
                            r_q     <= w_dvd_mag;
                            r_d     <= w_dvs_mag;
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            r_state <= CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                            r_q_neg <= Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                            r_r_neg <= Dividend[WIDTH-1];
`endif
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                CALC: begin
                    r_p   <= w_p_next;
                    r_q   <= {r_q[WIDTH-2:0], w_q_bit};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    r_p     <= {1'b0, w_rem_fix};
                    r_state <= NEG;
`else
                    r_quotient  <= r_q;
                    r_remainder <= w_rem_fix;
                    r_dbz       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
`endif
                end
`ifdef SEQ_DIVIDER_SIGNED_EN
                NEG: begin
                    // Most-negative / -1 wraps naturally: |q| = 2^(W-1), no negation.
                    r_quotient  <= r_q_neg ? (~r_q + 1'b1) : r_q;
                    r_remainder <= r_r_neg ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0];
                    r_dbz       <= 1'b0;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
`endif
                DONE: begin
                    if (Out_Ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign In_Ready    = r_in_ready;
    assign Out_Valid   = r_out_valid;
    assign Quotient    = r_quotient;
    assign Remainder   = r_remainder;
    assign Div_By_Zero = r_dbz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table-driven vectors, hand-written
// stall/reset sequences and random operands against a reference model.
module tb_seq_divider;

    localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dvd = '0;
    logic [W-1:0] dvs = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(W)) dut (
        .CLK        (clk),
        .RST_n      (rst_n),
        .In_Valid   (in_valid),
        .In_Ready   (in_ready),
        .Dividend   (dvd),
        .Divisor    (dvs),
        .Out_Valid  (out_valid),
        .Out_Ready  (out_ready),
        .Quotient   (quo),
        .Remainder  (rem),
        .Div_By_Zero(dbz),
        .o_dbg_state(dbg_state)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
        int           hold;
    } vec_t;

    logic [2*W:0] exp_q[$];   // {dbz, quotient, remainder}
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] ma, mb, q, r;
        logic sa, sb;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
`ifdef SEQ_DIVIDER_SIGNED_EN
        sa = a[W-1];
        sb = b[W-1];
`else
        sa = 1'b0;
        sb = 1'b0;
`endif
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        q = ma / mb;
        r = ma % mb;
        if (sa ^ sb) q = -q;
        if (sa) r = -r;
        return {1'b0, q, r};
    endfunction

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                          input int exp_lat, input bit noise, input logic [2*W:0] exp);
        int n;
        logic [2*W:0] e;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        dvd = a;
        dvs = b;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 100) begin
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                dvd = W'($urandom);
                dvs = W'($urandom);
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("out_valid_seen", out_valid, 1);
        if (exp_lat != 0) check("latency", n, exp_lat);
        for (int h = 0; h < hold; h++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_result", {dbz, quo, rem}, exp);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        check("queue_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("result", {dbz, quo, rem}, e);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1);
        check("out_valid_after_hs", out_valid, 0);
    endtask

    vec_t tbl[10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [W-1:0] ra, rb;

`ifdef SEQ_DIVIDER_SIGNED_EN
        tbl = '{
            '{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT, 0},
            '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, 0},
            '{8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, LAT, 0},
            '{8'hF9, 8'hFE, 8'h03, 8'hFF, 1'b0, LAT, 0},
            '{8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1,   0},
            '{8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, LAT, 0},
            '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, LAT, 0},
            '{8'h7F, 8'h80, 8'h00, 8'h7F, 1'b0, LAT, 0},
            '{8'hC8, 8'h0D, 8'hFC, 8'hFC, 1'b0, LAT, 6},
            '{8'hF9, 8'h00, 8'hFF, 8'hF9, 1'b1, 1,   2}
        };
`else
        tbl = '{
            '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, LAT, 0},
            '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1,   0},
            '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, LAT, 0},
            '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0, LAT, 0},
            '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0, LAT, 6},
            '{8'd250, 8'd16,  8'd15,  8'd10,  1'b0, LAT, 0},
            '{8'd1,   8'd255, 8'd0,   8'd1,   1'b0, LAT, 0},
            '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, LAT, 0},
            '{8'd128, 8'd128, 8'd1,   8'd0,   1'b0, LAT, 2},
            '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, LAT, 0}
        };
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quo, 0);
        check("rst_remainder", rem, 0);
        check("rst_dbz", dbz, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);

        // Table vectors, applied back to back
        for (int i = 0; i < 10; i++) begin
            do_div(tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].lat, 1'b0,
                   {tbl[i].z, tbl[i].q, tbl[i].r});
        end

        // Reset on the 4th CALC cycle drops the division
        dvd = 8'd77;
        dvs = 8'd9;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_state_calc", dbg_state, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_quotient", quo, 0);
        check("midrst_remainder", rem, 0);
        check("midrst_dbz", dbz, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_state", dbg_state, 0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("no_result_after_rst", seen, 0);
        do_div(8'd9, 8'd9, 0, LAT, 1'b0, {1'b0, 8'd1, 8'd0});

        // Random operands with In_Valid noise while busy
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = (i % 8 == 0) ? '0 : W'($urandom_range(1, 255));
            do_div(ra, rb, $urandom_range(0, 2), (rb == '0) ? 1 : LAT, 1'b1, model(ra, rb));
        end

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative, sequential non-restoring divider. It is the inverse-direction companion of the combinational mul/div cell array.
- Retires one quotient bit per clock through a single reusable add/subtract row.
- Sits between the operand register file and the result bus.
- Uses a valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 8, operand, quotient and remainder width in bits (≥2).

Ports:
- CLK  input  1  clock; all state changes on the rising edge
- RST_n  input  1  synchronous, active-low reset
- In_Valid  input  1  operands present
- In_Ready  output  1  divider able to accept operands
- Dividend  input  WIDTH  numerator
- Divisor  input  WIDTH  denominator
- Out_Valid  output  1  result present
- Out_Ready  input  1  consumer accepts result
- Quotient  output  WIDTH  quotient
- Remainder  output  WIDTH  remainder
- Div_By_Zero  output  1  result came from a zero divisor

Behaviour:
- Reset: one clock, synchronous and active-low. Sampling RST_n=0 at a rising edge forces:
  - state IDLE
  - In_Ready=0 during the reset cycle, then 1 afterwards
  - Out_Valid=0, Quotient=0, Remainder=0, Div_By_Zero=0
  - This applies mid-operation as well: any in-flight division is dropped with no output.
- States: IDLE, CALC, FIX, DONE.
- In_Ready=1 only in IDLE. Acceptance happens when In_Valid & In_Ready at an edge. The operands are latched and the ports are not sampled again until the next IDLE.
- IDLE -> CALC on accept with Divisor≠0. Initial values:
  - partial remainder P = 0, WIDTH+1 bits, two's complement
  - Q register = Dividend
  - bit counter = WIDTH-1
- IDLE -> DONE on accept with Divisor=0. Results:
  - Quotient = all ones
  - Remainder = Dividend
  - Div_By_Zero = 1
- CALC, one iteration per cycle:
  - Shift {P,Q} left by 1.
  - If the old P≥0, P -= D; otherwise P += D.
  - The new Q LSB is the inverted sign of the new P.
  - The counter decrements. When it is 0, go to FIX.
- FIX: if P<0, P += D. Then go to DONE.
- DONE: Out_Valid=1. Quotient, Remainder and Div_By_Zero hold stable until Out_Valid & Out_Ready, then go to IDLE.
  - Out_Ready low stalls the divider indefinitely; In_Ready stays 0.
- Latency:
  - Divisor≠0: the edge after acceptance begins CALC, and Out_Valid rises WIDTH+2 cycles after the accepting edge. For WIDTH=8 this is 10 cycles.
  - Divisor=0: Out_Valid rises 1 cycle after the accepting edge.
- Arithmetic: unsigned in base configuration. Remainder < Divisor always. Quotient×Divisor+Remainder = Dividend exactly.
- Back-to-back throughput: one division per WIDTH+3 cycles minimum. In_Ready returns 1 the cycle after the output handshake.
- In_Valid asserted outside IDLE is ignored. There is no queueing.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- When defined, operands are two's complement:
  - Magnitudes are taken at accept; the quotient sign is sign(Dividend) XOR sign(Divisor); the remainder sign follows the Dividend.
  - Truncation is toward zero.
  - One extra NEG state is inserted between FIX and DONE, so latency becomes WIDTH+3.
  - Overflow case, most-negative / -1: Quotient = most-negative value (wraps), Remainder = 0, Div_By_Zero = 0.
  - Zero divisor: Quotient = all ones, Remainder = Dividend.
- When undefined: no NEG state and no sign logic; behaviour is purely unsigned as above.

Decomposition:
- Shared package seq_divider_pkg:
  - state enumeration IDLE/CALC/FIX/NEG/DONE
  - default WIDTH constant
  - counter width constant, clog2(WIDTH)
- One sub-module, div_step: combinational WIDTH+1-bit add/subtract row.
  - Inputs: P, D, shift-in bit, op select.
  - Outputs: new P and quotient bit.
  - It is the single-row analogue of the cell array, and is reused each CALC cycle and in FIX.

Test Plan:
- WIDTH=8, accept 100/7 with Out_Ready=1 -> Out_Valid 10 cycles after accept, Quotient=14, Remainder=2, Div_By_Zero=0.
- Accept 5/0 -> Out_Valid 1 cycle after accept, Quotient=0xFF, Remainder=5, Div_By_Zero=1.
- Accept 255/1 then immediately 0/3 -> 255 r0, then 0 r0. Second In_Ready rises the cycle after the first output handshake.
- Accept 200/13 with Out_Ready held 0 for 6 cycles after Out_Valid -> Quotient=15, Remainder=5 stable throughout, In_Ready=0 until handshake.
- Accept 77/9, assert RST_n=0 on the 4th CALC cycle -> next cycle Out_Valid=0, outputs 0, no result ever issued; then 9/9 -> 1 r0.
- With SEQ_DIVIDER_SIGNED_EN: -7/2 -> Quotient=0xFD, Remainder=0xFF at 11 cycles; 0x80/0xFF -> Quotient=0x80, Remainder=0.
